// File: rtl/scope_pkg.sv
// Shared scope types: dump FSM states, channel-select codes, RAM geometry.
package scope_pkg;
  localparam int DEPTH  = 512;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, RD, LAT, SEND, WAIT, DONE} dump_state_e;

  localparam logic [1:0] CH1     = 2'b00;
  localparam logic [1:0] CH2     = 2'b01;
  localparam logic [1:0] CH3     = 2'b10;
  localparam logic [1:0] CH_RSVD = 2'b11;
endpackage

// File: rtl/dump_addr_gen.sv
// Read pointer and byte counter for a channel dump; last flags the final byte.
module dump_addr_gen #(
  parameter int DEPTH  = scope_pkg::DEPTH,
  parameter int ADDR_W = scope_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic              last
);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] count;

  // Oldest sample is one past the newest; ADDR_W-bit arithmetic gives the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      count  <= '0;
    end else if (load) begin
      rd_ptr <= base + ADDR_W'(1);
      count  <= '0;
    end else if (inc) begin
      rd_ptr <= rd_ptr + ADDR_W'(1);
      count  <= count + ADDR_W'(1);
    end
  end

  assign last = (count == LAST_CNT);
endmodule

// File: rtl/chan_dump.sv
// Channel-dump engine: streams one channel RAM, oldest first, to the UART path.
module chan_dump #(
  parameter int DEPTH  = scope_pkg::DEPTH,
  parameter int ADDR_W = scope_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_req,
  input  logic [1:0]        dump_ch,
  input  logic              capture_done,
  input  logic [ADDR_W-1:0] trace_end,
  input  logic [7:0]        ch1_rdata,
  input  logic [7:0]        ch2_rdata,
  input  logic [7:0]        ch3_rdata,
  output logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        resp_data,
  output logic              send_resp,
  input  logic              resp_sent,
  output logic              dump_busy,
  output logic              dump_done,
  output logic              dump_err
);
  import scope_pkg::*;

  dump_state_e state;
  logic [1:0]  ch_sel;
  logic        accept, inc, last;
  logic [7:0]  rdata_sel;

  assign accept = (state == IDLE) && dump_req && capture_done && (dump_ch != CH_RSVD);
  assign inc    = (state == WAIT) && resp_sent && !last;

  dump_addr_gen #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .inc    (inc),
    .base   (trace_end),
    .rd_ptr (addr),
    .last   (last)
  );

  always_comb begin
    rdata_sel = ch1_rdata;
    case (ch_sel)
      CH2:     rdata_sel = ch2_rdata;
      CH3:     rdata_sel = ch3_rdata;
      default: rdata_sel = ch1_rdata;
    endcase
  end

  // en is raised on the edge that enters RD so it is high only during RD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ch_sel    <= CH1;
      en        <= 1'b0;
      resp_data <= '0;
      send_resp <= 1'b0;
      dump_busy <= 1'b0;
      dump_done <= 1'b0;
      dump_err  <= 1'b0;
    end else begin
      en        <= 1'b0;
      send_resp <= 1'b0;
      dump_done <= 1'b0;
      dump_err  <= 1'b0;
      case (state)
        IDLE: if (dump_req) begin
          if (accept) begin
            ch_sel    <= dump_ch;
            dump_busy <= 1'b1;
            en        <= 1'b1;
            state     <= RD;
          end else begin
            dump_err  <= 1'b1;
          end
        end
        RD:   state <= LAT;
        LAT:  state <= SEND;
        SEND: begin
          resp_data <= rdata_sel;
          send_resp <= 1'b1;
          state     <= WAIT;
        end
        WAIT: if (resp_sent) begin
          if (last) begin
            dump_done <= 1'b1;
            state     <= DONE;
          end else begin
            en        <= 1'b1;
            state     <= RD;
          end
        end
        DONE: begin
          dump_busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/chan_dump.md
Name: chan_dump

Overview:
- Channel-dump engine directly downstream of the capture stage.
- After a capture completes, a DUMP_CH command causes it to read the selected channel's 512-entry RAM in chronological order, oldest sample first. The oldest sample sits at trace_end+1 (mod 512).
- Each byte is handed to the UART response path over the send_resp/resp_sent handshake.
- The command/config FSM owns the request; this block owns RAM read sequencing during a dump.

Parameters:
- DEPTH, 512, samples per channel RAM; a power of two.
- ADDR_W, 9, RAM address width; log2(DEPTH).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- dump_req  input  1  one-cycle request to start a dump.
- dump_ch  input  2  channel select: 00=ch1, 01=ch2, 10=ch3, 11=reserved.
- capture_done  input  1  high when a valid trace is held in RAM.
- trace_end  input  ADDR_W  address of the newest captured sample.
- ch1_rdata  input  8  RAM channel 1 read data.
- ch2_rdata  input  8  RAM channel 2 read data.
- ch3_rdata  input  8  RAM channel 3 read data.
- en  output  1  RAM read enable.
- addr  output  ADDR_W  RAM read address.
- resp_data  output  8  byte to UART.
- send_resp  output  1  one-cycle pulse that starts a UART byte.
- resp_sent  input  1  UART byte finished.
- dump_busy  output  1  high from accept until return to IDLE.
- dump_done  output  1  one-cycle pulse after the last byte's resp_sent.
- dump_err  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset: one clock. rst is asynchronous, active-high, and forces the following:
  - state = IDLE;
  - en = 0, addr = 0, resp_data = 0;
  - send_resp = 0, dump_busy = 0, dump_done = 0, dump_err = 0;
  - internal count = 0.
  - Reset mid-dump aborts immediately. No dump_done is produced, and any UART byte in flight is the UART's concern.
- All outputs are registered.
- RAM model: synchronous read. Data for the addr presented with en=1 at edge k is valid on chX_rdata after edge k+1.
- States:
  - IDLE:
    - dump_req with capture_done=1 and dump_ch!=11 → accept. Latch ch_sel; rd_ptr = trace_end+1 (mod DEPTH, 511 wraps to 0); count = 0; dump_busy = 1; go to RD.
    - dump_req with dump_ch=11 or capture_done=0 → dump_err pulse; stay in IDLE.
  - RD: en=1, addr=rd_ptr for exactly one cycle; go to LAT.
  - LAT: en=0; wait the one-cycle RAM latency; go to SEND.
  - SEND: resp_data = the rdata selected by ch_sel; send_resp pulses for 1 cycle; go to WAIT.
  - WAIT:
    - resp_data is held stable.
    - On resp_sent: if count==DEPTH-1, go to DONE; otherwise count+1, rd_ptr+1 (mod DEPTH), go to RD.
    - resp_sent in any state other than WAIT is ignored.
  - DONE: dump_done pulses 1 cycle; dump_busy = 0; go to IDLE.
- dump_req while busy is ignored: no error, no restart.
- Changes on dump_ch, trace_end or capture_done after accept have no effect on the current dump.
- Exactly DEPTH bytes are sent per dump. The address sequence is trace_end+1, …, DEPTH-1, 0, …, trace_end.
- Minimum cost per byte is 4 cycles (RD, LAT, SEND, WAIT with resp_sent arriving immediately).
- Accept-to-first-send_resp latency is 3 cycles.
- count is ADDR_W bits wide. The terminal test is count==DEPTH-1, with no overflow past it.
- en is never asserted outside RD. The capture/RAM-interface block gives this block's addr/en priority while dump_busy=1.

Decomposition:
- Shared package (scope_pkg):
  - dump state enum {IDLE, RD, LAT, SEND, WAIT, DONE};
  - channel-select constants CH1=2'b00, CH2=2'b01, CH3=2'b10, CH_RSVD=2'b11;
  - DEPTH/ADDR_W defaults.
- One natural sub-module, dump_addr_gen: holds the rd_ptr/count registers plus load, increment and terminal flag. The FSM and the data mux stay in chan_dump.

Test Plan:
- trace_end=9'h0FF, capture_done=1, dump_ch=01, ch2 RAM[i]=i[7:0], resp_sent returned 2 cycles after each send_resp → 512 bytes 00 (addr 256) … FF, then 00 … FF (addr 255); dump_done once; addresses wrap 511→0.
- trace_end=9'h1FF, dump_ch=00 → first addr=0, last addr=511; first send_resp exactly 3 cycles after accept.
- dump_ch=11, capture_done=1 → dump_err pulse only; en/send_resp never assert; dump_busy stays 0.
- capture_done=0, dump_ch=10 → dump_err pulse, no RAM reads.
- A second dump_req 10 cycles into a dump with dump_ch changed to 10 → ignored; all bytes still from the original channel; one dump_done.
- rst pulsed mid-dump at byte 37 → all outputs 0 asynchronously; a subsequent request restarts from trace_end+1; stray resp_sent during IDLE is ignored.
